// File: rtl/mat_stream_reader_pkg.sv
// Shared types for the frame-RAM stream reader/writer: FSM states and the pixel beat.
// MAT_READER_EOL_EN adds an end-of-line flag to every beat.
package mat_pkg;

    localparam int MAT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } mat_state_e;

    typedef struct packed {
        logic [MAT_DATA_W-1:0] data;
        logic                  sof;
        logic                  eof;
`ifdef MAT_READER_EOL_EN
        logic                  eol;
`endif
    } mat_beat_t;

endpackage

// File: rtl/mat_stream_reader_if.sv
// RAM read port plus pixel stream; master = reader, slave = RAM/downstream side.
// MAT_READER_EOL_EN adds out_eol.
interface mat_stream_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_oe;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rd_q;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sof;
    logic                  out_eof;
`ifdef MAT_READER_EOL_EN
    logic                  out_eol;
`endif

    modport master (
        output mem_addr, mem_oe, mem_we,
        input  mem_rd_q,
        output out_data, out_valid, out_sof, out_eof,
`ifdef MAT_READER_EOL_EN
        output out_eol,
`endif
        input  out_ready
    );

    modport slave (
        input  mem_addr, mem_oe, mem_we,
        output mem_rd_q,
        input  out_data, out_valid, out_sof, out_eof,
`ifdef MAT_READER_EOL_EN
        input  out_eol,
`endif
        output out_ready
    );
endinterface

// File: rtl/mat_stream_reader_beat_fifo2.sv
// Two-entry synchronous FIFO of pixel beats; push and pop may coincide.
module beat_fifo2
    import mat_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  mat_beat_t din,
    output mat_beat_t head,
    output logic [1:0] count
);
    mat_beat_t  mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/mat_stream_reader.sv
// Raster-order frame reader: sweeps ROWS x COLS pixels from a 1-cycle-latency RAM into a
// valid/ready stream with sof/eof tags. Define MAT_READER_EOL_EN to add out_eol.
module mat_stream_reader
    import mat_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int COLS       = 16,
    parameter int ROWS       = 16,
    parameter int BASE_ADDR  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    mat_stream_reader_if.master bus
);
    localparam int FRAME = COLS * ROWS;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);

    if (COLS < 1 || ROWS < 1) begin : g_bad_dims
        $error("mat_stream_reader: COLS and ROWS must be at least 1");
    end
    if (FRAME > (32'sd1 << ADDR_WIDTH)) begin : g_bad_frame
        $error("mat_stream_reader: frame does not fit the address space");
    end
    if (BASE_ADDR + FRAME > (32'sd1 << ADDR_WIDTH)) begin : g_bad_base
        $error("mat_stream_reader: frame at BASE_ADDR runs past the end of RAM");
    end
    if (DATA_WIDTH != MAT_DATA_W) begin : g_bad_width
        $error("mat_stream_reader: DATA_WIDTH must match the beat data width");
    end

    mat_state_e            state_r, state_s;
    logic [ADDR_WIDTH-1:0] idx_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [COL_W-1:0]      col_r;
    logic [ROW_W-1:0]      row_r;
    logic                  inflight_r;
    logic                  sof_tag_r, eof_tag_r, eol_tag_r;
    logic                  busy_r, done_r;

    logic                  issue_s, drain_done_s, room_s, pop_s, valid_s;
    logic                  last_idx_s, col_last_s, row_last_s;
    logic [2:0]            occupancy_s;
    logic [1:0]            fifo_left_s;
    logic [1:0]            fifo_count_s;
    mat_beat_t             push_beat_s, head_s;

    assign valid_s     = (fifo_count_s != 2'd0);
    assign pop_s       = valid_s & bus.out_ready;
    // Entries that will be held once everything already requested has landed.
    assign occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign room_s      = (occupancy_s < 3'd2);
    assign fifo_left_s = fifo_count_s - {1'b0, pop_s};
    assign last_idx_s  = (idx_r == ADDR_WIDTH'(FRAME - 1));
    assign col_last_s  = (col_r == COL_W'(COLS - 1));
    assign row_last_s  = (row_r == ROW_W'(ROWS - 1));

    // Next-state and read-issue decision.
    always_comb begin
        state_s      = state_r;
        issue_s      = 1'b0;
        drain_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                issue_s = room_s;
                if (room_s && last_idx_s) state_s = DRAIN;
                else                      state_s = RUN;
            end
            DRAIN: begin
                if (!inflight_r && (fifo_left_s == 2'd0)) begin
                    drain_done_s = 1'b1;
                    state_s      = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state, raster counters, in-flight tag and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            addr_r     <= BASE_A;
            col_r      <= '0;
            row_r      <= '0;
            inflight_r <= 1'b0;
            sof_tag_r  <= 1'b0;
            eof_tag_r  <= 1'b0;
            eol_tag_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s != IDLE);
            done_r     <= drain_done_s;
            inflight_r <= issue_s;
            if (state_r == IDLE && start) begin
                idx_r <= '0;
                col_r <= '0;
                row_r <= '0;
            end else if (issue_s) begin
                idx_r     <= idx_r + ADDR_WIDTH'(1);
                addr_r    <= BASE_A + idx_r;
                sof_tag_r <= (col_r == '0) && (row_r == '0);
                eof_tag_r <= col_last_s && row_last_s;
                eol_tag_r <= col_last_s;
                if (col_last_s) begin
                    col_r <= '0;
                    row_r <= row_last_s ? '0 : row_r + ROW_W'(1);
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end
        end
    end

    // RAM data is only sampled in the cycle right after an issued read.
    always_comb begin
        push_beat_s      = '0;
        push_beat_s.data = bus.mem_rd_q;
        push_beat_s.sof  = sof_tag_r;
        push_beat_s.eof  = eof_tag_r;
`ifdef MAT_READER_EOL_EN
        push_beat_s.eol  = eol_tag_r;
`endif
    end

    beat_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_r),
        .pop   (pop_s),
        .din   (push_beat_s),
        .head  (head_s),
        .count (fifo_count_s)
    );

    assign bus.mem_oe    = issue_s;
    assign bus.mem_addr  = issue_s ? (BASE_A + idx_r) : addr_r;
    assign bus.mem_we    = 1'b0;
    assign bus.out_valid = valid_s;
    assign bus.out_data  = head_s.data;
    assign bus.out_sof   = head_s.sof;
    assign bus.out_eof   = head_s.eof;
`ifdef MAT_READER_EOL_EN
    assign bus.out_eol   = head_s.eol;
`else
    logic unused_eol_s;
    assign unused_eol_s  = eol_tag_r;
`endif
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_mat_stream_reader.sv
// Scoreboard bench for mat_stream_reader: a 4x4 frame at a nonzero base plus a 1x1 frame.
module tb_mat_stream_reader;
    localparam int BASE = 32;

    logic clk, rst;
    logic start, busy, done;
    logic start1, busy1, done1;
    logic [7:0] ram  [256];
    logic [7:0] ram1 [256];

    int checks = 0;
    int errors = 0;
    int outstanding = 0;
    int reads_issued = 0;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       eol;
    } exp_t;
    exp_t exp_q[$];

    mat_stream_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
    mat_stream_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus1 ();

    mat_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .COLS(4), .ROWS(4), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
    );
    mat_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .COLS(1), .ROWS(1), .BASE_ADDR(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM models; garbage when no read was issued.
    always @(posedge clk) bus.mem_rd_q  <= bus.mem_oe  ? ram[bus.mem_addr]   : 8'hEE;
    always @(posedge clk) bus1.mem_rd_q <= bus1.mem_oe ? ram1[bus1.mem_addr] : 8'hEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.data = 8'(i);
            e.sof  = (i == 0);
            e.eof  = (i == 15);
            e.eol  = ((i % 4) == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        push_frame();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Leaves the caller at the negedge of the done cycle when seen.
    task automatic wait_done(input string name, input bit toggle);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                if (toggle) bus.out_ready = ~bus.out_ready;
            end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Monitor: compares the head against the scoreboard and watches read headroom.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 0;
            end else begin
                int hs;
                hs = (bus.out_valid && bus.out_ready) ? 1 : 0;
                if (bus.mem_oe) begin
                    chk("read_headroom", 32'(outstanding - hs < 2), 32'd1);
                    reads_issued++;
                end
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {24'd0, bus.out_data}, 32'hFFFF_FFFF);
                    end else begin
                        chk("beat_data", {24'd0, bus.out_data}, {24'd0, exp_q[0].data});
                        chk("beat_sof", 32'(bus.out_sof), 32'(exp_q[0].sof));
                        chk("beat_eof", 32'(bus.out_eof), 32'(exp_q[0].eof));
`ifdef MAT_READER_EOL_EN
                        chk("beat_eol", 32'(bus.out_eol), 32'(exp_q[0].eol));
`endif
                        if (bus.out_ready) void'(exp_q.pop_front());
                    end
                end
                outstanding = outstanding + (bus.mem_oe ? 1 : 0) - hs;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]  = 8'h5A;
            ram1[i] = 8'h3C;
        end
        for (int i = 0; i < 16; i++) ram[BASE + i] = 8'(i);
        ram1[0] = 8'hA5;
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        bus.out_ready = 1'b1; bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);

        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_oe", 32'(bus.mem_oe), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", {24'd0, bus.mem_addr}, 32'(BASE));
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", {24'd0, bus.out_data}, 32'd0);
        chk("rst_sof", 32'(bus.out_sof), 32'd0);
        chk("rst_eof", 32'(bus.out_eof), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-rate frame with exact cycle timing.
        start_frame();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("t1_busy", 32'(busy), 32'(c <= 18));
            chk("t1_valid", 32'(bus.out_valid), 32'(c >= 3 && c <= 18));
            chk("t1_done", 32'(done), 32'(c == 19));
            chk("t1_oe", 32'(bus.mem_oe), 32'(c <= 16));
            chk("t1_we", 32'(bus.mem_we), 32'd0);
            if (c == 1) chk("t1_addr0", {24'd0, bus.mem_addr}, 32'(BASE));
            if (c == 3) chk("t1_first_sof", 32'(bus.out_sof), 32'd1);
            @(posedge clk); #1;
        end
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // Ready toggling every cycle.
        start_frame();
        wait_done("t2_done", 1'b1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        chk("t2_drained", 32'(exp_q.size()), 32'd0);

        // Long stall right after the first valid.
        bus.out_ready = 1'b0;
        reads_issued = 0;
        start_frame();
        for (int k = 0; k < 10 && !bus.out_valid; k++) @(negedge clk);
        chk("t3_valid_seen", 32'(bus.out_valid), 32'd1);
        repeat (10) @(negedge clk);
        chk("t3_reads", 32'(reads_issued), 32'd2);
        chk("t3_held", {24'd0, bus.out_data}, 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_done("t3_done", 1'b0);
        @(posedge clk); #1;
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Ignored mid-frame start, then back-to-back start on the done cycle.
        start_frame();
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t4_done_a", 1'b0);
        start = 1'b1;
        push_frame();
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t4_b2b_addr", {24'd0, bus.mem_addr}, 32'(BASE));
        chk("t4_b2b_oe", 32'(bus.mem_oe), 32'd1);
        chk("t4_b2b_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        wait_done("t4_done_b", 1'b0);
        @(posedge clk); #1;
        chk("t4_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame around pixel 7.
        start_frame();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_data == 8'd7) break;
            @(posedge clk); #1;
        end
        chk("t5_px7", {24'd0, bus.out_data}, 32'd7);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_valid", 32'(bus.out_valid), 32'd0);
            chk("t5_busy", 32'(busy), 32'd0);
            chk("t5_oe", 32'(bus.mem_oe), 32'd0);
            chk("t5_done", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        start_frame();
        wait_done("t5_restart_done", 1'b0);
        @(posedge clk); #1;
        chk("t5_drained", 32'(exp_q.size()), 32'd0);

        // Single-pixel frame.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("t6_busy", 32'(busy1), 32'(c <= 3));
            chk("t6_oe", 32'(bus1.mem_oe), 32'(c == 1));
            chk("t6_valid", 32'(bus1.out_valid), 32'(c == 3));
            chk("t6_done", 32'(done1), 32'(c == 4));
            if (c == 3) begin
                chk("t6_data", {24'd0, bus1.out_data}, 32'hA5);
                chk("t6_sof", 32'(bus1.out_sof), 32'd1);
                chk("t6_eof", 32'(bus1.out_eof), 32'd1);
`ifdef MAT_READER_EOL_EN
                chk("t6_eol", 32'(bus1.out_eol), 32'd1);
`endif
            end
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
